// File: rtl/seg7_pkg.sv
// Shared constants and hex decode table for the seven-segment scan driver.
package seg7_pkg;

    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Active-low {a,b,c,d,e,f,g}; entry n is glyph n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'b0111000, 7'b0110000, 7'b1000010, 7'b0110001,
        7'b1100000, 7'b0001000, 7'b0000100, 7'b0000000,
        7'b0001111, 7'b0100000, 7'b0100100, 7'b1001100,
        7'b0000110, 7'b0010010, 7'b1001111, 7'b0000001
    };

    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        return SEG_TABLE[nib];
    endfunction

endpackage

// File: rtl/seg7_scan_mux_if.sv
// Display-side bundle: digit data and controls in, segment/anode pins out.
interface seg7_scan_mux_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [DIGITS-1:0]   blank;
    logic                lzb;
    logic [3:0]          bright;
    logic                load;
    logic [6:0]          seg;
    logic                dp_n;
    logic [DIGITS-1:0]   an_n;
    logic                frame_done;

    modport master (
        output data, dp, blank, lzb, bright, load,
        input  seg, dp_n, an_n, frame_done
    );

    modport slave (
        input  data, dp, blank, lzb, bright, load,
        output seg, dp_n, an_n, frame_done
    );
endinterface

// File: rtl/seg7_hex_dec.sv
// Combinational hex nibble to active-low segment decoder.
module seg7_hex_dec
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);
    assign seg_o = hex_to_seg(nib_i);
endmodule

// File: rtl/seg7_scan_mux.sv
// Multiplexed common-anode display driver: double-buffered digits,
// leading-zero blanking, guard time and PWM brightness.
module seg7_scan_mux
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 50000,
    parameter int GUARD    = 16
) (
    input  logic            clk,
    input  logic            resett,
    seg7_scan_mux_if.slave  bus
);
    localparam int CW = $clog2(PRESCALE);
    localparam int IW = $clog2(DIGITS);
    localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
    localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD);
    localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

    logic [CW-1:0]            cnt_q, cnt_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [3:0]               pwm_q;
    logic [DIGITS-1:0][3:0]   pend_data_q, act_data_q;
    logic [DIGITS-1:0]        pend_dp_q, act_dp_q;
    logic [DIGITS-1:0]        pend_blank_q, act_blank_q;
    logic [6:0]               seg_q, seg_d, dec_seg;
    logic                     dp_n_q, dp_n_d;
    logic [DIGITS-1:0]        an_n_q, an_n_d;
    logic                     fd_q, fd_d, tick;
    logic [DIGITS-1:0]        lz;
    logic                     allz, sup;

    always_comb begin
        tick  = (cnt_q == CNT_LAST);
        fd_d  = tick && (idx_q == IDX_LAST);
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        idx_d = idx_q;
        if (tick) idx_d = fd_d ? '0 : idx_q + 1'b1;
    end

    // lz[i]: every active nibble from i upward is zero; digit 0 stays lit.
    always_comb begin
        lz   = '0;
        allz = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            allz  = allz && (act_data_q[i] == 4'h0);
            lz[i] = allz;
        end
    end

    seg7_hex_dec u_dec (
        .nib_i (act_data_q[idx_q]),
        .seg_o (dec_seg)
    );

    always_comb begin
        sup    = act_blank_q[idx_q] | (bus.lzb & lz[idx_q]);
        seg_d  = sup ? SEG_BLANK : dec_seg;
        dp_n_d = sup | ~act_dp_q[idx_q];
        an_n_d = '1;
        if (cnt_q >= CNT_GUARD && pwm_q <= bus.bright)
            an_n_d[idx_q] = 1'b0;
    end

    always_ff @(posedge clk or negedge resett) begin
        if (!resett) begin
            cnt_q        <= '0;
            idx_q        <= '0;
            pwm_q        <= '0;
            pend_data_q  <= '0;
            pend_dp_q    <= '0;
            pend_blank_q <= '0;
            act_data_q   <= '0;
            act_dp_q     <= '0;
            act_blank_q  <= '0;
            seg_q        <= SEG_BLANK;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            fd_q         <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            pwm_q  <= pwm_q + 4'd1;
            seg_q  <= seg_d;
            dp_n_q <= dp_n_d;
            an_n_q <= an_n_d;
            fd_q   <= fd_d;
            // Frame end promotes the old pending set; a coincident load
            // lands in pending only.
            if (fd_d) begin
                act_data_q  <= pend_data_q;
                act_dp_q    <= pend_dp_q;
                act_blank_q <= pend_blank_q;
            end
            if (bus.load) begin
                pend_data_q  <= bus.data;
                pend_dp_q    <= bus.dp;
                pend_blank_q <= bus.blank;
            end
        end
    end

    assign bus.seg        = seg_q;
    assign bus.dp_n       = dp_n_q;
    assign bus.an_n       = an_n_q;
    assign bus.frame_done = fd_q;

endmodule

// File: doc/seg7_scan_mux.md
# seg7_scan_mux

Time-multiplexed driver for a common-anode multi-digit seven-segment display: holds DIGITS hex nibbles, scans them one digit per slot, decodes 0-F to active-low segments, and adds decimal points, per-digit blanking, leading-zero suppression, anti-ghosting guard time and 16-level brightness. Sits between the UART/clock control logic and the board display pins. Replaces per-digit static decoders with a single shared decoder.

## Interface
- DIGITS, 4: number of digits, 2..8.
- PRESCALE, 50000: clocks per digit slot, at least 4.
- GUARD, 16: clocks at slot start with all anodes off, less than PRESCALE.
- clk  in  1  system clock, rising edge.
- resett  in  1  asynchronous, active-low reset.
- data  in  4*DIGITS  hex value; nibble i (data[4i+3:4i]) is digit i; digit 0 is least significant.
- dp  in  DIGITS  decimal point request per digit, active-high.
- blank  in  DIGITS  force digit off, active-high.
- lzb  in  1  leading-zero blanking enable.
- bright  in  4  brightness, 0 = 1/16 duty, 15 = full.
- load  in  1  one-cycle strobe; captures data/dp/blank into the pending buffer.
- seg  out  7  segments {a,b,c,d,e,f,g}, active-low (a = bit 6, g = bit 0).
- dp_n  out  1  decimal point, active-low.
- an_n  out  DIGITS  anode enables, active-low, at most one low.
- frame_done  out  1  one-cycle pulse when the last slot of a frame ends.

## Operation
- Slot counter cnt runs 0..PRESCALE-1, then wraps. Tick = (cnt == PRESCALE-1).
- Digit index idx advances on tick, DIGITS-1 -> 0 wrap. frame_done = tick && idx == DIGITS-1.
- Double buffering:
  - load captures into the pending buffer.
  - Pending copies to the active buffer on frame_done, so a frame never mixes old and new values.
  - load in the same cycle as frame_done: the new values go to pending only, and take effect next frame.
- Decode: 0..F, active-low.
  - 0=0000001, 1=1001111, 2=0010010, 3=0000110, 4=1001100, 5=0100100, 6=0100000, 7=0001111.
  - 8=0000000, 9=0000100, A=0001000, b=1100000, C=0110001, d=1000010, E=0110000, F=0111000.
- Digit i is suppressed when any of these holds:
  - blank[i] = 1.
  - lzb = 1, i > 0, and every active nibble at index ≥ i is zero.
- Digit 0 is never suppressed by lzb.
- A suppressed digit drives seg = 1111111 and dp_n = 1. Its anode still follows the normal scan.
- PWM: a 4-bit counter pwm increments every clock and wraps.
- Anode drive: an_n[idx] = 0 only when cnt ≥ GUARD and pwm ≤ bright. All other anode bits are 1.

## Timing
- Reset (resett = 0, asynchronous) forces:
  - cnt = 0, idx = 0, pwm = 0.
  - active and pending buffers all zero.
  - seg = 1111111, dp_n = 1, an_n = all 1, frame_done = 0.
- Reset release: first anode low at cnt = GUARD, registered output one cycle later.
- All outputs are registered: seg/dp_n/an_n reflect idx, cnt and pwm with 1-cycle latency; frame_done is asserted in the cycle after the tick.
- A load arriving mid-frame reaches the display 1 cycle after the next frame_done.
- Reset mid-frame: all outputs blank immediately; the pending buffer is discarded.

## Structure
- Package seg7_pkg holds:
  - SEG_BLANK = 7'b1111111.
  - the 16-entry hex-to-segment constant table.
  - function hex_to_seg(nibble).
- One combinational sub-module, seg7_hex_dec (nibble in, 7-bit active-low segments out), instantiated once on the muxed active nibble.
- Everything else stays in the top module: prescaler, idx, pwm, buffers, lzb mask and output registers.

## Test plan
All scenarios use DIGITS=4, PRESCALE=8, GUARD=1.
- Hex sweep:
  - stimulus: load data=16'h3210, bright=15, lzb=0.
  - response: after the next frame_done, slot idx 0..3 drives seg 0000001, 1001111, 0010010, 0000110 with an_n 1110, 1101, 1011, 0111, each low for cnt 1..7 only.
- Double buffer:
  - stimulus: load 16'hAAAA mid-frame, then load 16'hBBBB in the same cycle as frame_done.
  - response: the next frame shows all A (0001000) and the following frame all b (1100000); no frame shows a mix.
- Leading zeros:
  - stimulus: data=16'h0050, lzb=1.
  - response: digits 3 and 2 give seg 1111111; digit 1 shows 5 (0100100); digit 0 shows 0.
  - with data=16'h0000: only digit 0 is lit.
- Blank and dp:
  - stimulus: blank=4'b0100, dp=4'b0110.
  - response: digit 2 is dark with dp_n=1; digit 1 has dp_n=0; digits 0 and 3 have dp_n=1.
- Brightness:
  - stimulus: bright=0 and bright=7.
  - response: per slot, the anode is low only in cycles with pwm=0, respectively pwm ≤ 7; it is never low at cnt=0.
- Reset mid-frame:
  - stimulus: assert resett=0 during slot 2.
  - response: seg, dp_n and an_n go all-1 without waiting for a clock edge.
  - after release: idx restarts at 0 and the display shows 0 until the next load and frame_done.
